// File: rtl/gemclct_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gemclct_pkg                                                              |
// | Shared widths, FIFO entry layout and decoder FSM encoding.               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package gemclct_pkg;

  localparam int CAND_N  = 8;
  localparam int WIN_W   = 3;
  localparam int PRI_W   = 10;
  localparam int XKY_W   = 10;
  localparam int ENTRY_W = WIN_W + PRI_W + XKY_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DEAD = 1'b1
  } state_e;

  function automatic logic [CAND_N-1:0] win_onehot(input logic [WIN_W-1:0] win);
    return CAND_N'(1) << win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gemclct_sfifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gemclct_sfifo                                                            |
// | Show-ahead synchronous FIFO, async reset, sticky overflow on drop.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gemclct_sfifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic                     ovf_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             ovf_q;

  logic             empty_w, full_w, do_rd_w, do_wr_w;

  assign empty_w = (cnt_q == '0);
  assign full_w  = (cnt_q == (AW+1)'(DEPTH));
  assign do_rd_w = rd_en_i && !empty_w;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign do_wr_w = wr_en_i && (!full_w || do_rd_w);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_wr_w) wptr_q <= wptr_q + 1'b1;
      if (do_rd_w) rptr_q <= rptr_q + 1'b1;
      case ({do_wr_w, do_rd_w})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (wr_en_i && !do_wr_w) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr_w) mem_q[wptr_q] <= wr_data_i;
  end

  assign rd_data_o = empty_w ? '0 : mem_q[rptr_q];
  assign empty_o   = empty_w;
  assign full_o    = full_w;
  assign cnt_o     = cnt_q;
  assign ovf_o     = ovf_q;

endmodule
`default_nettype wire

// File: rtl/gemclct_win_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gemclct_win_decoder                                                      |
// | Confirms the GEM-CLCT winner, applies pri cut and dead time, decodes the |
// | window to one-hot and buffers accepts. GEMCLCT_DEC_STATS_EN adds counts. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gemclct_win_decoder
  import gemclct_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DEAD_W     = 4
) (
  input  logic                        clock,
  input  logic                        global_reset,
  input  logic                        best_vld,
  input  logic [CAND_N-1:0]           match_vpf,
  input  logic [WIN_W-1:0]            win_best,
  input  logic [PRI_W-1:0]            pri_best,
  input  logic [XKY_W-1:0]            gem_xky_best,
  input  logic [PRI_W-1:0]            pri_max,
  input  logic [DEAD_W-1:0]           dead_bx,
  output logic                        match_vld,
  output logic [CAND_N-1:0]           match_onehot,
  output logic [PRI_W-1:0]            match_pri,
  output logic [XKY_W-1:0]            match_xky,
  input  logic                        rd_en,
  output logic [ENTRY_W-1:0]          rd_data,
  output logic                        fifo_empty,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
  output logic                        fifo_ovf
`ifdef GEMCLCT_DEC_STATS_EN
  ,
  output logic [15:0]                 n_accept,
  output logic [15:0]                 n_reject
`endif
);

  state_e              state_q, state_d;
  logic [DEAD_W-1:0]   dead_q, dead_d;

  logic                accept_w;
  logic [ENTRY_W-1:0]  entry_w;

  logic                vld_q;
  logic [CAND_N-1:0]   onehot_q;
  logic [PRI_W-1:0]    pri_q;
  logic [XKY_W-1:0]    xky_q;

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      state_q <= IDLE;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      dead_q  <= dead_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dead_d  = dead_q;
    case (state_q)
      IDLE: begin
        if (accept_w && (dead_bx != '0)) begin
          state_d = DEAD;
          dead_d  = dead_bx;
        end
      end
      DEAD: begin
        // Leave on the 1->0 step; the <= also guards a stray zero count.
        if (dead_q <= DEAD_W'(1)) begin
          state_d = IDLE;
          dead_d  = '0;
        end else begin
          dead_d  = dead_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        dead_d  = '0;
      end
    endcase
  end

  always_comb begin
    accept_w = best_vld && match_vpf[win_best] && (pri_best <= pri_max)
               && (state_q == IDLE);
    entry_w  = {win_best, pri_best, gem_xky_best};
  end

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      vld_q    <= 1'b0;
      onehot_q <= '0;
      pri_q    <= '0;
      xky_q    <= '0;
    end else if (accept_w) begin
      vld_q    <= 1'b1;
      onehot_q <= win_onehot(win_best);
      pri_q    <= pri_best;
      xky_q    <= gem_xky_best;
    end else begin
      vld_q    <= 1'b0;
      onehot_q <= '0;
      pri_q    <= '0;
      xky_q    <= '0;
    end
  end

  assign match_vld    = vld_q;
  assign match_onehot = onehot_q;
  assign match_pri    = pri_q;
  assign match_xky    = xky_q;

  gemclct_sfifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clock),
    .rst_i     (global_reset),
    .wr_en_i   (accept_w),
    .wr_data_i (entry_w),
    .rd_en_i   (rd_en),
    .rd_data_o (rd_data),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .cnt_o     (fifo_cnt),
    .ovf_o     (fifo_ovf)
  );

`ifdef GEMCLCT_DEC_STATS_EN
  logic [15:0] n_accept_q, n_reject_q;

  // Rejects include valid cycles swallowed by the dead time.
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      n_accept_q <= '0;
      n_reject_q <= '0;
    end else begin
      if (accept_w && (n_accept_q != 16'hFFFF)) n_accept_q <= n_accept_q + 1'b1;
      if (best_vld && !accept_w && (n_reject_q != 16'hFFFF)) n_reject_q <= n_reject_q + 1'b1;
    end
  end

  assign n_accept = n_accept_q;
  assign n_reject = n_reject_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gemclct_win_decoder.sv
`default_nettype none
// Self-checking bench for gemclct_win_decoder: directed scenarios plus a
// randomized run against a cycle-count / queue reference model.
module tb_gemclct_win_decoder;

  localparam int DEPTH = 4;

  logic        clock;
  logic        global_reset;
  logic        best_vld;
  logic [7:0]  match_vpf;
  logic [2:0]  win_best;
  logic [9:0]  pri_best;
  logic [9:0]  gem_xky_best;
  logic [9:0]  pri_max;
  logic [3:0]  dead_bx;
  logic        match_vld;
  logic [7:0]  match_onehot;
  logic [9:0]  match_pri;
  logic [9:0]  match_xky;
  logic        rd_en;
  logic [22:0] rd_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic [2:0]  fifo_cnt;
  logic        fifo_ovf;
`ifdef GEMCLCT_DEC_STATS_EN
  logic [15:0] n_accept;
  logic [15:0] n_reject;
`endif

  gemclct_win_decoder #(.FIFO_DEPTH(DEPTH), .DEAD_W(4)) dut (
    .clock        (clock),
    .global_reset (global_reset),
    .best_vld     (best_vld),
    .match_vpf    (match_vpf),
    .win_best     (win_best),
    .pri_best     (pri_best),
    .gem_xky_best (gem_xky_best),
    .pri_max      (pri_max),
    .dead_bx      (dead_bx),
    .match_vld    (match_vld),
    .match_onehot (match_onehot),
    .match_pri    (match_pri),
    .match_xky    (match_xky),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_cnt     (fifo_cnt),
    .fifo_ovf     (fifo_ovf)
`ifdef GEMCLCT_DEC_STATS_EN
    ,
    .n_accept     (n_accept),
    .n_reject     (n_reject)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: accepts gated by an absolute "earliest cycle" number,
  // FIFO contents held in a queue.
  int          cyc     = 0;
  int          next_ok = 0;
  logic [22:0] q[$];
  logic        m_ovf;
  logic        exp_vld;
  logic [7:0]  exp_oh;
  logic [9:0]  exp_pri, exp_xky;
  int          m_acc, m_rej;

  function automatic logic [22:0] mk(input int w, input int p, input int x);
    return {3'(w), 10'(p), 10'(x)};
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    next_ok = 0;
    exp_vld = 1'b0;
    exp_oh  = '0;
    exp_pri = '0;
    exp_xky = '0;
    m_acc   = 0;
    m_rej   = 0;
  endtask

  task automatic model_step();
    bit acc;
    acc = best_vld && match_vpf[win_best] && (pri_best <= pri_max) && (cyc >= next_ok);
    exp_vld = acc;
    exp_oh  = acc ? (8'h01 << win_best) : 8'h00;
    exp_pri = acc ? pri_best : 10'd0;
    exp_xky = acc ? gem_xky_best : 10'd0;
    if (acc) next_ok = cyc + int'(dead_bx) + 1;
    if (rd_en && q.size() > 0) void'(q.pop_front());
    if (acc) begin
      if (q.size() < DEPTH) q.push_back({win_best, pri_best, gem_xky_best});
      else m_ovf = 1'b1;
    end
    if (acc && m_acc < 65535) m_acc++;
    if (best_vld && !acc && m_rej < 65535) m_rej++;
  endtask

  task automatic clk_step();
    model_step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    best_vld     = 1'b0;
    match_vpf    = 8'h00;
    win_best     = 3'd0;
    pri_best     = 10'd0;
    gem_xky_best = 10'd0;
    pri_max      = 10'd0;
    dead_bx      = 4'd0;
    rd_en        = 1'b0;
  endtask

  task automatic drive(input int w, input int vpf, input int p, input int pm,
                       input int x, input int d);
    best_vld     = 1'b1;
    win_best     = 3'(w);
    match_vpf    = 8'(vpf);
    pri_best     = 10'(p);
    pri_max      = 10'(pm);
    gem_xky_best = 10'(x);
    dead_bx      = 4'(d);
  endtask

  task automatic do_reset();
    global_reset = 1'b1;
    #1;
    model_reset();
    #1;
    global_reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    global_reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({match_vld, match_onehot, match_pri, match_xky} !== 29'd0)
      $display("FAIL reset_match got %b/%h/%0d/%0d required 0", match_vld, match_onehot, match_pri, match_xky);
    else n_pass++;
    n_checks++;
    if ({fifo_empty, fifo_full, fifo_cnt, fifo_ovf} !== 6'b1_0_000_0)
      $display("FAIL reset_fifo got e=%b f=%b c=%0d o=%b required e=1 f=0 c=0 o=0", fifo_empty, fifo_full, fifo_cnt, fifo_ovf);
    else n_pass++;
    n_checks++;
    if (rd_data !== 23'd0) $display("FAIL reset_rd_data got %h required 0", rd_data);
    else n_pass++;
    #1;
    global_reset = 1'b0;
  endtask

  task automatic test_single_accept();
    do_reset();
    drive(5, 8'h20, 12, 20, 300, 0);
    clk_step();
    idle_inputs();
    n_checks++;
    if ({match_vld, match_onehot} !== {1'b1, 8'h20})
      $display("FAIL single_vld_oh got %b/%h required 1/20", match_vld, match_onehot);
    else n_pass++;
    n_checks++;
    if ({match_pri, match_xky} !== {10'd12, 10'd300})
      $display("FAIL single_pri_xky got %0d/%0d required 12/300", match_pri, match_xky);
    else n_pass++;
    n_checks++;
    if (rd_data !== mk(5, 12, 300)) $display("FAIL single_rd_data got %h required %h", rd_data, mk(5, 12, 300));
    else n_pass++;
    n_checks++;
    if (fifo_cnt !== 3'd1) $display("FAIL single_cnt got %0d required 1", fifo_cnt);
    else n_pass++;
    clk_step();
    n_checks++;
    if ({match_vld, match_onehot, match_pri, match_xky} !== 29'd0)
      $display("FAIL single_clear got %b/%h/%0d/%0d required 0", match_vld, match_onehot, match_pri, match_xky);
    else n_pass++;
  endtask

  task automatic test_rejections();
    do_reset();
    drive(2, 8'hFB, 5, 20, 7, 0);
    clk_step();
    n_checks++;
    if (match_vld !== 1'b0) $display("FAIL rej_nomatch got %b required 0", match_vld);
    else n_pass++;
    drive(3, 8'hFF, 21, 20, 8, 0);
    clk_step();
    n_checks++;
    if (match_vld !== 1'b0) $display("FAIL rej_pricut got %b required 0", match_vld);
    else n_pass++;
    drive(3, 8'hFF, 20, 20, 9, 0);
    clk_step();
    idle_inputs();
    n_checks++;
    if ({match_vld, match_onehot, match_pri} !== {1'b1, 8'h08, 10'd20})
      $display("FAIL rej_boundary got %b/%h/%0d required 1/08/20", match_vld, match_onehot, match_pri);
    else n_pass++;
    n_checks++;
    if (fifo_cnt !== 3'd1) $display("FAIL rej_cnt got %0d required 1", fifo_cnt);
    else n_pass++;
  endtask

  task automatic test_dead_time();
    int w;
    do_reset();
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w = int'($urandom_range(0, 7));
      drive(w, 1 << w, 3, 10, i, 3);
      clk_step();
      n_checks++;
      if (match_vld !== ((i % 4) == 0)) $display("FAIL dead3_cyc%0d got %b required %b", i, match_vld, (i % 4) == 0);
      else n_pass++;
    end
    do_reset();
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(i, 8'hFF, 1, 10, 50 + i, 0);
      clk_step();
      n_checks++;
      if ({match_vld, match_xky} !== {1'b1, 10'(50 + i)})
        $display("FAIL dead0_cyc%0d got %b/%0d required 1/%0d", i, match_vld, match_xky, 50 + i);
      else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_fifo_overflow();
    logic [22:0] tail [3];
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      drive(k, 8'hFF, k, 1023, 100 + k, 0);
      clk_step();
      if (k == 4) begin
        n_checks++;
        if ({fifo_full, fifo_ovf} !== 2'b10) $display("FAIL ovf_full4 got f=%b o=%b required f=1 o=0", fifo_full, fifo_ovf);
        else n_pass++;
      end
    end
    n_checks++;
    if ({fifo_ovf, fifo_cnt, fifo_full} !== {1'b1, 3'd4, 1'b1})
      $display("FAIL ovf_after5 got o=%b c=%0d f=%b required o=1 c=4 f=1", fifo_ovf, fifo_cnt, fifo_full);
    else n_pass++;
    n_checks++;
    if (rd_data !== mk(1, 1, 101)) $display("FAIL ovf_head1 got %h required %h", rd_data, mk(1, 1, 101));
    else n_pass++;
    drive(6, 8'hFF, 6, 1023, 106, 0);
    rd_en = 1'b1;
    clk_step();
    best_vld = 1'b0;
    n_checks++;
    if ({fifo_cnt, rd_data} !== {3'd4, mk(2, 2, 102)})
      $display("FAIL ovf_rdwr got c=%0d h=%h required c=4 h=%h", fifo_cnt, rd_data, mk(2, 2, 102));
    else n_pass++;
    tail[0] = mk(3, 3, 103);
    tail[1] = mk(4, 4, 104);
    tail[2] = mk(6, 6, 106);
    for (int i = 0; i < 3; i++) begin
      clk_step();
      n_checks++;
      if (rd_data !== tail[i]) $display("FAIL ovf_drain%0d got %h required %h", i, rd_data, tail[i]);
      else n_pass++;
    end
    clk_step();
    n_checks++;
    if ({fifo_empty, fifo_cnt, rd_data, fifo_ovf} !== {1'b1, 3'd0, 23'd0, 1'b1})
      $display("FAIL ovf_empty got e=%b c=%0d h=%h o=%b required e=1 c=0 h=0 o=1", fifo_empty, fifo_cnt, rd_data, fifo_ovf);
    else n_pass++;
    rd_en = 1'b1;
    clk_step();
    n_checks++;
    if ({fifo_empty, fifo_cnt} !== {1'b1, 3'd0}) $display("FAIL rd_empty got e=%b c=%0d required e=1 c=0", fifo_empty, fifo_cnt);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_empty_rdwr();
    do_reset();
    drive(1, 8'h02, 4, 9, 77, 0);
    rd_en = 1'b1;
    clk_step();
    idle_inputs();
    n_checks++;
    if ({fifo_empty, fifo_cnt, rd_data} !== {1'b0, 3'd1, mk(1, 4, 77)})
      $display("FAIL empty_rdwr got e=%b c=%0d h=%h required e=0 c=1 h=%h", fifo_empty, fifo_cnt, rd_data, mk(1, 4, 77));
    else n_pass++;
  endtask

  task automatic test_reset_mid_dead();
    do_reset();
    drive(0, 8'h01, 2, 5, 11, 0);
    clk_step();
    drive(7, 8'h80, 2, 5, 12, 5);
    clk_step();
    idle_inputs();
    clk_step();
    n_checks++;
    if (fifo_cnt !== 3'd2) $display("FAIL rstdead_pre_cnt got %0d required 2", fifo_cnt);
    else n_pass++;
    global_reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({fifo_empty, fifo_cnt, fifo_ovf, match_vld} !== {1'b1, 3'd0, 1'b0, 1'b0})
      $display("FAIL rstdead_async got e=%b c=%0d o=%b v=%b required e=1 c=0 o=0 v=0", fifo_empty, fifo_cnt, fifo_ovf, match_vld);
    else n_pass++;
    #1;
    global_reset = 1'b0;
    drive(4, 8'h10, 3, 5, 13, 0);
    clk_step();
    idle_inputs();
    n_checks++;
    if ({match_vld, match_onehot, match_xky} !== {1'b1, 8'h10, 10'd13})
      $display("FAIL rstdead_accept got %b/%h/%0d required 1/10/13", match_vld, match_onehot, match_xky);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      best_vld     = ($urandom_range(0, 9) < 7);
      match_vpf    = 8'($urandom);
      win_best     = 3'($urandom);
      pri_best     = 10'($urandom);
      pri_max      = 10'($urandom_range(200, 900));
      gem_xky_best = 10'($urandom);
      dead_bx      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      rd_en        = ($urandom_range(0, 1) == 1);
      clk_step();
      n_checks++;
      if ({match_vld, match_onehot, match_pri, match_xky} !== {exp_vld, exp_oh, exp_pri, exp_xky})
        $display("FAIL rnd_match_%0d got %b/%h/%0d/%0d required %b/%h/%0d/%0d", i,
                 match_vld, match_onehot, match_pri, match_xky, exp_vld, exp_oh, exp_pri, exp_xky);
      else n_pass++;
      n_checks++;
      if ({fifo_empty, fifo_full, fifo_cnt, fifo_ovf} !== {q.size() == 0, q.size() == DEPTH, 3'(q.size()), m_ovf})
        $display("FAIL rnd_status_%0d got e=%b f=%b c=%0d o=%b required c=%0d o=%b", i,
                 fifo_empty, fifo_full, fifo_cnt, fifo_ovf, q.size(), m_ovf);
      else n_pass++;
      n_checks++;
      if (rd_data !== ((q.size() > 0) ? q[0] : 23'd0))
        $display("FAIL rnd_head_%0d got %h required %h", i, rd_data, (q.size() > 0) ? q[0] : 23'd0);
      else n_pass++;
    end
    idle_inputs();
  endtask

`ifdef GEMCLCT_DEC_STATS_EN
  task automatic test_stats();
    do_reset();
    rd_en = 1'b1;
    drive(1, 8'hFF, 30, 20, 1, 0); clk_step();
    drive(2, 8'hFF, 25, 20, 2, 0); clk_step();
    drive(3, 8'hFF, 5, 20, 3, 0);  clk_step();
    drive(4, 8'hFF, 5, 20, 4, 0);  clk_step();
    drive(5, 8'hFF, 5, 20, 5, 2);  clk_step();
    drive(6, 8'hFF, 5, 20, 6, 0);  clk_step();
    idle_inputs();
    clk_step();
    n_checks++;
    if ({n_accept, n_reject} !== {16'd3, 16'd3})
      $display("FAIL stats_counts got a=%0d r=%0d required a=3 r=3", n_accept, n_reject);
    else n_pass++;
    best_vld  = 1'b1;
    match_vpf = 8'h00;
    for (int i = 0; i < 65536; i++) clk_step();
    idle_inputs();
    clk_step();
    n_checks++;
    if ({n_accept, n_reject} !== {16'd3, 16'hFFFF})
      $display("FAIL stats_sat got a=%0d r=%h required a=3 r=ffff", n_accept, n_reject);
    else n_pass++;
    n_checks++;
    if ({n_accept, n_reject} !== {16'(m_acc), 16'(m_rej)})
      $display("FAIL stats_model got a=%0d r=%0d required a=%0d r=%0d", n_accept, n_reject, m_acc, m_rej);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_accept();
    test_rejections();
    test_dead_time();
    test_fifo_overflow();
    test_empty_rdwr();
    test_reset_mid_dead();
    test_random();
`ifdef GEMCLCT_DEC_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
